dram_burst_queue: RTL and testbench

DRAM_BURST_QUEUE -- requirements
Module: dram_burst_queue

---
 rtl/dram_burst_queue.sv | 106 ++++++++++
 tb/tb_dram_burst_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dram_burst_queue.sv
// dram_burst_queue: FIFO of scratchpad row requests, each issued to DRAM as one read beat or BEATS write beats.
// Define DRAM_BURST_QUEUE_HWM_EN to add the hwm output (registered peak occupancy since reset).
module dram_burst_queue #(
    parameter int DEPTH  = 16,
    parameter int LANES  = 32,
    parameter int LANE_W = 16,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 8,
    localparam int ROW_W = LANES * LANE_W,
    localparam int BEATS = ROW_W / BEAT_W,
    localparam int LPB   = BEAT_W / LANE_W,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH),
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic              enq_write,
    input  logic [ID_W-1:0]   enq_id,
    input  logic [ADDR_W-1:0] enq_addr,
    input  logic [LANES-1:0]  enq_mask,
    input  logic [ROW_W-1:0]  enq_wdata,
    output logic              dram_valid,
    input  logic              dram_ready,
    output logic              dram_write,
    output logic [ID_W-1:0]   dram_id,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [BEAT_W-1:0] dram_wdata,
    output logic [LPB-1:0]    dram_strb,
    output logic              dram_last,
    output logic              txn_done,
    output logic [CW-1:0]     count
`ifdef DRAM_BURST_QUEUE_HWM_EN
    ,
    output logic [CW-1:0]     hwm
`endif
);
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state, state_nxt;
    logic              wr_mem   [DEPTH];
    logic [ID_W-1:0]   id_mem   [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [LANES-1:0]  mask_mem [DEPTH];
    logic [ROW_W-1:0]  data_mem [DEPTH];
    logic [PW-1:0]     head, tail;
    logic [BW-1:0]     beat_cnt;
    logic [CW-1:0]     count_nxt;
    logic              push, pop, beat_ok, head_wr;

    // enq_ready is forced low while reset is asserted, then reflects free space
    assign enq_ready = n_rst && (count < CW'(DEPTH));
    assign push      = enq_valid && enq_ready;
    assign head_wr   = wr_mem[head];

    always_comb begin
        dram_valid = state == ISSUE;
        beat_ok    = dram_valid && dram_ready;
        dram_last  = dram_valid && (!head_wr || beat_cnt == BW'(BEATS - 1));
        pop        = beat_ok && dram_last;
        txn_done   = pop;
        count_nxt  = count + CW'(push) - CW'(pop);
        state_nxt  = count_nxt != '0 ? ISSUE : IDLE;
        dram_write = dram_valid && head_wr;
        dram_id    = dram_valid ? id_mem[head] : '0;
        dram_addr  = dram_valid ? addr_mem[head] + ADDR_W'(beat_cnt) * ADDR_W'(BEAT_W / 8) : '0;
        dram_wdata = dram_write ? data_mem[head][beat_cnt * BEAT_W +: BEAT_W] : '0;
        dram_strb  = !dram_valid ? '0 : head_wr ? mask_mem[head][beat_cnt * LPB +: LPB] : '1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            if (pop) beat_cnt <= '0;
            else if (beat_ok) beat_cnt <= beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wr_mem[tail]   <= enq_write;
            id_mem[tail]   <= enq_id;
            addr_mem[tail] <= enq_addr;
            mask_mem[tail] <= enq_mask;
            data_mem[tail] <= enq_wdata;
        end
    end

`ifdef DRAM_BURST_QUEUE_HWM_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) hwm <= '0;
        else if (count > hwm) hwm <= count;
    end
`endif
endmodule

// File: tb/tb_dram_burst_queue.sv
// tb_dram_burst_queue: directed self-checking bench for dram_burst_queue with default parameters.
module tb_dram_burst_queue;
    logic         clk = 0;
    logic         n_rst = 0;
    logic         enq_valid = 0, enq_ready, enq_write = 0;
    logic [7:0]   enq_id = 0;
    logic [31:0]  enq_addr = 0, enq_mask = 0;
    logic [511:0] enq_wdata = 0;
    logic         dram_valid, dram_ready = 0, dram_write, dram_last, txn_done;
    logic [7:0]   dram_id;
    logic [31:0]  dram_addr;
    logic [63:0]  dram_wdata;
    logic [3:0]   dram_strb;
    logic [4:0]   count;
`ifdef DRAM_BURST_QUEUE_HWM_EN
    logic [4:0]   hwm;
`endif
    int n_checks = 0, n_fail = 0;
    logic [7:0] q[$];

    dram_burst_queue dut (
        .clk(clk), .n_rst(n_rst), .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_write(enq_write), .enq_id(enq_id), .enq_addr(enq_addr), .enq_mask(enq_mask),
        .enq_wdata(enq_wdata), .dram_valid(dram_valid), .dram_ready(dram_ready),
        .dram_write(dram_write), .dram_id(dram_id), .dram_addr(dram_addr),
        .dram_wdata(dram_wdata), .dram_strb(dram_strb), .dram_last(dram_last),
        .txn_done(txn_done), .count(count)
`ifdef DRAM_BURST_QUEUE_HWM_EN
        , .hwm(hwm)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] mk_row(input logic [15:0] b);
        logic [511:0] r;
        for (int i = 0; i < 32; i++) r[i*16 +: 16] = b + 16'(i);
        return r;
    endfunction

    function automatic logic [63:0] beat_of(input logic [15:0] b, input int k);
        return {16'(b + 4*k + 3), 16'(b + 4*k + 2), 16'(b + 4*k + 1), 16'(b + 4*k)};
    endfunction

    task automatic push(input logic wr, input logic [7:0] id, input logic [31:0] addr,
                        input logic [31:0] mask, input logic [511:0] data);
        enq_valid = 1; enq_write = wr; enq_id = id; enq_addr = addr; enq_mask = mask; enq_wdata = data;
        @(negedge clk);
        enq_valid = 0;
    endtask

    task automatic drain();
        int b = 0;
        dram_ready = 1;
        while ((count != 0 || dram_valid) && b < 100) begin
            @(negedge clk);
            b++;
        end
        chk("drain_count", 64'(count), 0);
        chk("drain_valid", 64'(dram_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int dones;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(dram_valid), 0);
        chk("rst_ready", 64'(enq_ready), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_done", 64'(txn_done), 0);
        chk("rst_addr", 64'(dram_addr), 0);
        n_rst = 1;
        @(negedge clk);
        chk("post_rst_ready", 64'(enq_ready), 1);

        // 8-beat write burst with dram_ready held high
        dram_ready = 1;
        dones = 0;
        push(1, 8'h5A, 32'h1000, 32'hFFFF_FFFF, mk_row(16'h0));
        chk("w_beat0_data", dram_wdata, 64'h0003_0002_0001_0000);
        for (int k = 0; k < 8; k++) begin
            chk("w_valid", 64'(dram_valid), 1);
            chk("w_addr", 64'(dram_addr), 64'(32'h1000 + 8*k));
            chk("w_data", dram_wdata, beat_of(16'h0, k));
            chk("w_strb", 64'(dram_strb), 4'hF);
            chk("w_id", 64'(dram_id), 8'h5A);
            chk("w_write", 64'(dram_write), 1);
            chk("w_last", 64'(dram_last), 64'(k == 7));
            dones += int'(txn_done);
            @(negedge clk);
        end
        chk("w_done_once", 64'(dones), 1);
        chk("w_empty_valid", 64'(dram_valid), 0);
        chk("w_empty_count", 64'(count), 0);

        // read with backpressure for 5 cycles
        dram_ready = 0;
        push(0, 8'h11, 32'h2000, 32'hFFFF_FFFF, '1);
        for (int c = 0; c < 5; c++) begin
            chk("r_valid", 64'(dram_valid), 1);
            chk("r_addr", 64'(dram_addr), 32'h2000);
            chk("r_data", dram_wdata, 0);
            chk("r_strb", 64'(dram_strb), 4'hF);
            chk("r_last", 64'(dram_last), 1);
            chk("r_write", 64'(dram_write), 0);
            chk("r_id", 64'(dram_id), 8'h11);
            chk("r_done_held", 64'(txn_done), 0);
            chk("r_count", 64'(count), 1);
            @(negedge clk);
        end
        dram_ready = 1;
        #1 chk("r_done", 64'(txn_done), 1);
        @(negedge clk);
        chk("r_count_after", 64'(count), 0);
        chk("r_valid_after", 64'(dram_valid), 0);

        // fill to full, ignored 17th push, FIFO-order drain
        dram_ready = 0;
        for (int i = 0; i < 16; i++) push(0, 8'(i), 32'h3000 + 32'(i) * 32'h40, 0, 0);
        chk("full_ready", 64'(enq_ready), 0);
        chk("full_count", 64'(count), 16);
        push(0, 8'hFF, 32'hDEAD, 0, 0);
        chk("full_17th_count", 64'(count), 16);
        dram_ready = 1;
        for (int i = 0; i < 16; i++) begin
            chk("fifo_id", 64'(dram_id), 64'(i));
            chk("fifo_addr", 64'(dram_addr), 64'(32'h3000 + 32'(i) * 32'h40));
            @(negedge clk);
        end
        chk("fifo_count", 64'(count), 0);
        chk("fifo_valid", 64'(dram_valid), 0);

        // simultaneous push/pop at count 3, then 40 streaming entries across wrap
        dram_ready = 0;
        for (int i = 0; i < 3; i++) push(0, 8'h20 + 8'(i), 32'h100, 0, 0);
        chk("sim_count_pre", 64'(count), 3);
        enq_valid = 1; enq_write = 0; enq_id = 8'h23; dram_ready = 1;
        #1 chk("sim_done", 64'(txn_done), 1);
        chk("sim_head", 64'(dram_id), 8'h20);
        @(negedge clk);
        enq_valid = 0;
        chk("sim_count", 64'(count), 3);
        q = '{8'h21, 8'h22, 8'h23};
        for (int j = 0; j < 40; j++) begin
            if (dram_valid && dram_last) chk("wrap_id", 64'(dram_id), 64'(q.pop_front()));
            enq_valid = 1; enq_write = 0; enq_id = 8'h30 + 8'(j);
            if (enq_ready) q.push_back(enq_id);
            @(negedge clk);
        end
        enq_valid = 0;
        chk("wrap_count", 64'(count), 3);
        for (int b = 0; b < 20 && q.size() > 0; b++) begin
            if (dram_valid) chk("wrap_tail_id", 64'(dram_id), 64'(q.pop_front()));
            @(negedge clk);
        end
        chk("wrap_q_empty", 64'(q.size()), 0);
        chk("wrap_end_count", 64'(count), 0);

        // reset in the middle of a write burst
        push(1, 8'h77, 32'h4000, 32'hFFFF_FFFF, mk_row(16'h0));
        repeat (4) @(negedge clk);
        chk("mid_beat4_addr", 64'(dram_addr), 32'h4020);
        n_rst = 0;
        #1 chk("mid_rst_valid", 64'(dram_valid), 0);
        chk("mid_rst_count", 64'(count), 0);
        chk("mid_rst_ready", 64'(enq_ready), 0);
        chk("mid_rst_id", 64'(dram_id), 0);
        @(negedge clk);
        n_rst = 1;
        #1 chk("mid_rel_ready", 64'(enq_ready), 1);
        chk("mid_rel_valid", 64'(dram_valid), 0);
        @(negedge clk);
        push(1, 8'h78, 32'h5000, 32'hA5C3_9E17, mk_row(16'h100));
        chk("mid_new_addr", 64'(dram_addr), 32'h5000);
        chk("mid_new_data", dram_wdata, 64'h0103_0102_0101_0100);
        chk("mid_new_strb0", 64'(dram_strb), 4'h7);
        chk("mid_new_id", 64'(dram_id), 8'h78);
        @(negedge clk);
        chk("mid_new_addr1", 64'(dram_addr), 32'h5008);
        chk("mid_new_strb1", 64'(dram_strb), 4'h1);
        chk("mid_new_data1", dram_wdata, beat_of(16'h100, 1));
        drain();

        // peak occupancy of 11
        dram_ready = 0;
        for (int i = 0; i < 11; i++) push(0, 8'h40 + 8'(i), 32'h6000, 0, 0);
        chk("peak_count", 64'(count), 11);
        chk("peak_head", 64'(dram_id), 8'h40);
        drain();
`ifdef DRAM_BURST_QUEUE_HWM_EN
        chk("hwm", 64'(hwm), 11);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
